// File: rtl/rca_bist_ctrl.sv
// Built-in self-test sequencer for a registered ripple-carry adder: sweeps every
// {a,b,cin} vector, checks each returned sum against a golden add and latches a verdict.
module rca_bist_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DUT_LAT = 1,
    parameter int ERR_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               cin_o,
    input  logic [WIDTH:0]     sum_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               first_fail_valid,
    output logic [2*WIDTH:0]   first_fail_vec
);

    localparam int VW = 2*WIDTH + 1;
    localparam int PD = DUT_LAT + 1;
    localparam int DW = $clog2(PD + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [VW-1:0]     vec_r;
    logic [DW-1:0]     drain_r;
    logic [VW-1:0]     pipe_vec_r [PD];
    logic [WIDTH:0]    pipe_exp_r [PD];
    logic [PD-1:0]     pipe_vld_r;
    logic              start_run_s;
    logic              launch_s;
    logic              last_s;
    logic              mismatch_s;
    logic              busy_s;
    logic              done_s;
    logic [ERR_W-1:0]  err_next_s;

    // Golden reference sum at full WIDTH+1 precision.
    function automatic logic [WIDTH:0] golden_sum(input logic [VW-1:0] v);
        return {1'b0, v[VW-1:WIDTH+1]} + {1'b0, v[WIDTH:1]} + {{WIDTH{1'b0}}, v[0]};
    endfunction

    assign start_run_s = ((state_r == S_IDLE) || (state_r == S_DONE)) && start;
    assign launch_s    = (state_r == S_DRIVE);
    assign last_s      = (vec_r == {VW{1'b1}});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (start) state_s = S_DRIVE; else state_s = S_IDLE;
            S_DRIVE: if (last_s) state_s = S_DRAIN; else state_s = S_DRIVE;
            S_DRAIN: if (drain_r == DW'(DUT_LAT)) state_s = S_DONE; else state_s = S_DRAIN;
            S_DONE:  if (start) state_s = S_DRIVE; else state_s = S_DONE;
            default: state_s = S_IDLE;
        endcase
    end

    // Status outputs decoded from the next state so the registered copies line up with it.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            S_DRIVE: busy_s = 1'b1;
            S_DRAIN: busy_s = 1'b1;
            S_DONE:  done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Compare the oldest pipe entry; the counter sticks once it reaches all-ones.
    always_comb begin
        mismatch_s = pipe_vld_r[PD-1] && (sum_i != pipe_exp_r[PD-1]);
        err_next_s = err_cnt;
        if (start_run_s) begin
            err_next_s = {ERR_W{1'b0}};
        end else if (mismatch_s && (err_cnt != {ERR_W{1'b1}})) begin
            err_next_s = err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_next_s = err_cnt;
        end
    end

    // Vector generation, expected-value pipe and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_r            <= {VW{1'b0}};
            drain_r          <= {DW{1'b0}};
            a_o              <= {WIDTH{1'b0}};
            b_o              <= {WIDTH{1'b0}};
            cin_o            <= 1'b0;
            pipe_vld_r       <= {PD{1'b0}};
            for (int i = 0; i < PD; i++) begin
                pipe_vec_r[i] <= {VW{1'b0}};
                pipe_exp_r[i] <= {(WIDTH+1){1'b0}};
            end
            err_cnt          <= {ERR_W{1'b0}};
            first_fail_valid <= 1'b0;
            first_fail_vec   <= {VW{1'b0}};
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            if (start_run_s) begin
                vec_r <= {VW{1'b0}};
            end else if (launch_s && !last_s) begin
                vec_r <= vec_r + {{(VW-1){1'b0}}, 1'b1};
            end
            if (launch_s) begin
                {a_o, b_o, cin_o} <= vec_r;
            end
            if (state_r == S_DRAIN) begin
                drain_r <= drain_r + {{(DW-1){1'b0}}, 1'b1};
            end else begin
                drain_r <= {DW{1'b0}};
            end
            pipe_vld_r[0] <= launch_s;
            pipe_vec_r[0] <= vec_r;
            pipe_exp_r[0] <= golden_sum(vec_r);
            for (int i = 1; i < PD; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_vec_r[i] <= pipe_vec_r[i-1];
                pipe_exp_r[i] <= pipe_exp_r[i-1];
            end
            err_cnt <= err_next_s;
            if (start_run_s) begin
                first_fail_valid <= 1'b0;
                first_fail_vec   <= {VW{1'b0}};
            end else if (mismatch_s && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= pipe_vec_r[PD-1];
            end
            busy <= busy_s;
            done <= done_s;
            pass <= done_s && (err_next_s == {ERR_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_rca_bist_ctrl.sv
// Directed bench for rca_bist_ctrl: a behavioural registered adder with selectable
// faults feeds the main instance; a second instance with a narrow counter sees a dead adder.
module tb_rca_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  a_o, b_o;
    logic        cin_o;
    logic [4:0]  sum_i;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic        ffv;
    logic [8:0]  ffvec;

    logic        start4;
    logic [3:0]  a4, b4;
    logic        cin4;
    logic        busy4, done4, pass4;
    logic [3:0]  err4;
    logic        ffv4;
    logic [8:0]  ffvec4;

    logic [4:0]  r1, r2;
    int          mode;
    int          total = 0;
    int          bad = 0;
    int          bc;
    bit          found;

    always #5 clk = ~clk;

    rca_bist_ctrl #(.WIDTH(4), .DUT_LAT(1), .ERR_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a_o), .b_o(b_o), .cin_o(cin_o), .sum_i(sum_i),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail_valid(ffv), .first_fail_vec(ffvec)
    );

    rca_bist_ctrl #(.WIDTH(4), .DUT_LAT(1), .ERR_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .a_o(a4), .b_o(b4), .cin_o(cin4), .sum_i(5'd0),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4),
        .first_fail_valid(ffv4), .first_fail_vec(ffvec4)
    );

    // Adder under test: one and two register stages of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1 <= 5'd0;
            r2 <= 5'd0;
        end else begin
            r1 <= {1'b0, a_o} + {1'b0, b_o} + {4'd0, cin_o};
            r2 <= r1;
        end
    end

    always_comb begin
        sum_i = r1;
        case (mode)
            1:       sum_i = {r1[4:1], 1'b0};
            2:       sum_i = r2;
            default: sum_i = r1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input bit hold, output int bcnt);
        bit fin;
        fin   = 1'b0;
        bcnt  = 0;
        start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                fin = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("run_completes", 32'(fin), 32'd1);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start4 = 1'b0;
        mode   = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_ops", 32'({a_o, b_o, cin_o, ffv, ffvec}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: clean run
        do_run(1'b0, bc);
        chk("t1_busy_cycles", 32'(bc), 32'd514);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err", 32'(err_cnt), 32'd0);
        chk("t1_ffv", 32'(ffv), 32'd0);
        chk("t1_ops_held", 32'({a_o, b_o, cin_o}), 32'h1FF);

        // 2: sum[0] stuck at 0
        mode = 1;
        do_run(1'b0, bc);
        chk("t2_err", 32'(err_cnt), 32'd256);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_ffv", 32'(ffv), 32'd1);
        chk("t2_ffvec", 32'(ffvec), 32'h001);

        // 3: adder latency 2 against a checker expecting 1
        mode = 2;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        do_run(1'b0, bc);
        chk("t3_pass", 32'(pass), 32'd0);
        chk("t3_ffvec", 32'(ffvec), 32'h001);
        chk("t3_err_nonzero", 32'(err_cnt != 16'd0), 32'd1);

        // 4: reset mid-run once the vector counter has reached 100
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ({a_o, b_o, cin_o} == 9'd99) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_reach_vec100", 32'(found), 32'd1);
        chk("t4_errs_before_rst", 32'(err_cnt != 16'd0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_err", 32'(err_cnt), 32'd0);
        chk("t4_outs", 32'({pass, ffv, ffvec, a_o, b_o, cin_o}), 32'd0);
        repeat (10) @(negedge clk);
        chk("t4_no_done", 32'(done), 32'd0);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("t4_rst_beats_start", 32'(busy), 32'd0);
        mode = 0;
        do_run(1'b0, bc);
        chk("t4_clean_busy", 32'(bc), 32'd514);
        chk("t4_clean_err", 32'(err_cnt), 32'd0);
        chk("t4_clean_pass", 32'(pass), 32'd1);

        // 5: start held through the run, then a fresh start from DONE
        mode = 1;
        do_run(1'b1, bc);
        chk("t5_busy_cycles", 32'(bc), 32'd514);
        chk("t5_err", 32'(err_cnt), 32'd256);
        repeat (5) @(negedge clk);
        chk("t5_stays_done", 32'({busy, done}), 32'b01);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_rerun_busy", 32'({busy, done}), 32'b10);
        chk("t5_rerun_err_clr", 32'(err_cnt), 32'd0);
        chk("t5_rerun_ffv_clr", 32'(ffv), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_rerun_done", 32'(found), 32'd1);
        chk("t5_rerun_pass", 32'(pass), 32'd1);

        // 6: narrow saturating counter against a dead adder
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("t6_busy", 32'(busy4), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done4) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_done", 32'(found), 32'd1);
        chk("t6_err_sat", 32'(err4), 32'hF);
        chk("t6_pass", 32'(pass4), 32'd0);
        chk("t6_ffv", 32'(ffv4), 32'd1);
        chk("t6_ffvec", 32'(ffvec4), 32'h001);
        chk("t6_ops_held", 32'({a4, b4, cin4}), 32'h1FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
